circulant_transpose_buffer: RTL and testbench

CIRCULANT_TRANSPOSE_BUFFER -- requirements
Module: circulant_transpose_buffer

---
 rtl/transpose_pkg.sv | 22 ++
 rtl/barrel_rotator.sv | 31 +++
 rtl/bram_mem.sv | 32 +++
 rtl/circulant_transpose_buffer.sv | 172 +++++++++++++++++
 tb/tb_circulant_transpose_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/transpose_pkg.sv
// ---------------------------------------------------------------------------
// transpose_pkg : read-mode encodings and circulant bank mapping. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package transpose_pkg;

   typedef enum logic {
      RMODE_ROW = 1'b0,
      RMODE_COL = 1'b1
   } rmode_e;

   // Element (r,c) lives in bank r+c; callers truncate the result to their
   // index width, which makes the sum modulo N for power-of-two N.
   function automatic logic [31:0] circ_bank(input logic [31:0] row_idx,
                                             input logic [31:0] col_idx);
      return row_idx + col_idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_rotator.sv
// ---------------------------------------------------------------------------
// barrel_rotator : log2(N)-stage element rotator, out[i] = in[(i+shift)%N].
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module barrel_rotator #(
   parameter int NUM_ELEM = 4,
   parameter int ELEM_W   = 8,
   parameter int SHIFT_W  = $clog2(NUM_ELEM)
) (
   input  logic [NUM_ELEM*ELEM_W-1:0] data_in,
   input  logic [SHIFT_W-1:0]         shift,
   output logic [NUM_ELEM*ELEM_W-1:0] data_out
);

   localparam int TOT_W = NUM_ELEM * ELEM_W;

   always_comb begin
      data_out = data_in;
      for (int s = 0; s < SHIFT_W; s++) begin
         if (shift[s]) begin
            data_out = (data_out >> ((1 << s) * ELEM_W)) |
                       (data_out << (TOT_W - (1 << s) * ELEM_W));
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bram_mem.sv
// ---------------------------------------------------------------------------
// bram_mem : simple dual-port RAM, registered read, read-first. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bram_mem #(
   parameter int DATAW = 8,
   parameter int DEPTH = 4,
   parameter int ADDRW = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADDRW-1:0] waddr,
   input  logic [DATAW-1:0] wdata,
   input  logic             re,
   input  logic [ADDRW-1:0] raddr,
   output logic [DATAW-1:0] rdata
);

   logic [DATAW-1:0] mem_q [DEPTH];
   logic [DATAW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/circulant_transpose_buffer.sv
// ---------------------------------------------------------------------------
// circulant_transpose_buffer : NxN matrix store with row and column (transpose)
// reads. Define CTB_OUTPUT_REG_EN to register the rotator output. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module circulant_transpose_buffer
   import transpose_pkg::*;
#(
   parameter int MATRIX_DIM = 4,
   parameter int MEM_WIDTH  = 8,
   parameter int ROW_WIDTH  = MATRIX_DIM * MEM_WIDTH,
   parameter int ADDR_LEN   = $clog2(MATRIX_DIM)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wen,
   input  logic [ADDR_LEN-1:0]  waddr,
   input  logic [ROW_WIDTH-1:0] wdata,
   input  logic                 ren,
   input  logic                 rmode,
   input  logic [ADDR_LEN-1:0]  raddr,
   output logic                 rvalid,
   output logic                 rmode_out,
   output logic [ROW_WIDTH-1:0] rdata
);

   if (MATRIX_DIM < 2 || (MATRIX_DIM & (MATRIX_DIM - 1)) != 0) begin : g_bad_dim
      $error("MATRIX_DIM must be a power of two and at least 2");
   end

   logic                 wen_q, wen_d;
   logic [ADDR_LEN-1:0]  waddr_q, waddr_d;
   logic [ROW_WIDTH-1:0] wdata_q, wdata_d;
   logic                 ren_q, ren_d;
   rmode_e               rmode_q, rmode_d;
   logic [ADDR_LEN-1:0]  raddr_q, raddr_d;
   logic                 ren2_q, ren2_d;
   rmode_e               rmode2_q, rmode2_d;
   logic [ADDR_LEN-1:0]  raddr2_q, raddr2_d;

   logic [ADDR_LEN-1:0]  bank_raddr [MATRIX_DIM];
   logic [MEM_WIDTH-1:0] bank_wdata [MATRIX_DIM];
   logic [ROW_WIDTH-1:0] fetch_vec;
   logic [ROW_WIDTH-1:0] rot_vec;

   // Column j: bank j+i serves row i. Write: element c goes to bank r+c.
   always_comb begin
      logic [ADDR_LEN-1:0] rd_bank;
      logic [ADDR_LEN-1:0] wr_bank;
      for (int b = 0; b < MATRIX_DIM; b++) begin
         bank_raddr[b] = raddr_q;
         bank_wdata[b] = '0;
      end
      for (int i = 0; i < MATRIX_DIM; i++) begin
         rd_bank = ADDR_LEN'(circ_bank(32'(raddr_q), 32'(i)));
         wr_bank = ADDR_LEN'(circ_bank(32'(waddr_q), 32'(i)));
         if (rmode_q == RMODE_COL) bank_raddr[rd_bank] = ADDR_LEN'(i);
         bank_wdata[wr_bank] = wdata_q[i*MEM_WIDTH +: MEM_WIDTH];
      end
   end

   for (genvar b = 0; b < MATRIX_DIM; b++) begin : g_bank
      bram_mem #(
         .DATAW (MEM_WIDTH),
         .DEPTH (MATRIX_DIM),
         .ADDRW (ADDR_LEN)
      ) u_bank (
         .clk   (clk),
         .we    (wen_q),
         .waddr (waddr_q),
         .wdata (bank_wdata[b]),
         .re    (ren_q),
         .raddr (bank_raddr[b]),
         .rdata (fetch_vec[b*MEM_WIDTH +: MEM_WIDTH])
      );
   end

   // Row r and column j both need out[i] = bank[(i + index) mod N].
   barrel_rotator #(
      .NUM_ELEM (MATRIX_DIM),
      .ELEM_W   (MEM_WIDTH),
      .SHIFT_W  (ADDR_LEN)
   ) u_rot (
      .data_in  (fetch_vec),
      .shift    (raddr2_q),
      .data_out (rot_vec)
   );

   always_comb begin
      wen_d    = wen;
      waddr_d  = waddr;
      wdata_d  = wdata;
      ren_d    = ren;
      rmode_d  = rmode_e'(rmode);
      raddr_d  = raddr;
      ren2_d   = ren_q;
      rmode2_d = ren_q ? rmode_q : rmode2_q;
      raddr2_d = ren_q ? raddr_q : raddr2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         ren_q    <= 1'b0;
         rmode_q  <= RMODE_ROW;
         raddr_q  <= '0;
         ren2_q   <= 1'b0;
         rmode2_q <= RMODE_ROW;
         raddr2_q <= '0;
      end else begin
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         ren_q    <= ren_d;
         rmode_q  <= rmode_d;
         raddr_q  <= raddr_d;
         ren2_q   <= ren2_d;
         rmode2_q <= rmode2_d;
         raddr2_q <= raddr2_d;
      end
   end

`ifdef CTB_OUTPUT_REG_EN
   logic                 rvalid_q, rvalid_d;
   logic                 rmode_out_q, rmode_out_d;
   logic [ROW_WIDTH-1:0] rdata_q, rdata_d;

   always_comb begin
      rvalid_d    = ren2_q;
      rmode_out_d = ren2_q ? rmode2_q : rmode_out_q;
      rdata_d     = ren2_q ? rot_vec : rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q    <= 1'b0;
         rmode_out_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         rvalid_q    <= rvalid_d;
         rmode_out_q <= rmode_out_d;
         rdata_q     <= rdata_d;
      end
   end

   assign rvalid    = rvalid_q;
   assign rmode_out = rmode_out_q;
   assign rdata     = rdata_q;
`else
   // Bank outputs are not reset, so rdata is masked until a read has landed.
   logic seen_q, seen_d;

   always_comb begin
      seen_d = seen_q | ren_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) seen_q <= 1'b0;
      else        seen_q <= seen_d;
   end

   assign rvalid    = ren2_q;
   assign rmode_out = rmode2_q;
   assign rdata     = seen_q ? rot_vec : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_circulant_transpose_buffer.sv
// ---------------------------------------------------------------------------
// tb_circulant_transpose_buffer : scoreboard bench for N=4, W=8. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_circulant_transpose_buffer;

`ifdef CTB_OUTPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wen = 1'b0;
   logic [1:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        ren = 1'b0;
   logic        rmode = 1'b0;
   logic [1:0]  raddr = '0;
   logic        rvalid;
   logic        rmode_out;
   logic [31:0] rdata;

   circulant_transpose_buffer #(
      .MATRIX_DIM (4),
      .MEM_WIDTH  (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wen       (wen),
      .waddr     (waddr),
      .wdata     (wdata),
      .ren       (ren),
      .rmode     (rmode),
      .raddr     (raddr),
      .rvalid    (rvalid),
      .rmode_out (rmode_out),
      .rdata     (rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        mode;
      int          issue;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [7:0]  mdl [4][4];
   logic [31:0] last_rdata = '0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input bit rm, input int idx);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = rm ? mdl[i][idx] : mdl[idx][i];
      return v;
   endfunction

   // One input cycle. When use_lit is set the literal is the expected value.
   task automatic step(input bit we, input int wa, input logic [31:0] wd,
                       input bit re, input bit rm, input int ra,
                       input bit use_lit = 1'b0, input logic [31:0] lit = '0);
      exp_t e;
      @(posedge clk);
      #2;
      wen   = we;
      waddr = wa[1:0];
      wdata = wd;
      ren   = re;
      rmode = rm;
      raddr = ra[1:0];
      if (re) begin
         e.data  = use_lit ? lit : model_read(rm, ra);
         e.mode  = rm;
         e.issue = cyc + 1;
         sb.push_back(e);
      end
      if (we) for (int c = 0; c < 4; c++) mdl[wa][c] = wd[c*8 +: 8];
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_n) begin
         check("rst_rvalid", {63'd0, rvalid}, 64'd0);
         check("rst_rdata", {32'd0, rdata}, 64'd0);
         last_rdata = '0;
      end else if (rvalid) begin
         if (sb.size() == 0) begin
            check("spurious_rvalid", {63'd0, rvalid}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("rdata", {32'd0, rdata}, {32'd0, mon_e.data});
            check("rmode_out", {63'd0, rmode_out}, {63'd0, mon_e.mode});
            check("latency", 64'(cyc - mon_e.issue), 64'(LAT));
         end
         last_rdata = rdata;
      end else begin
         check("rdata_hold", {32'd0, rdata}, {32'd0, last_rdata});
      end
   end

   initial begin
      logic [31:0] row;
      exp_t        e;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Element (r,c) = {r,c} nibbles.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) row[c*8 +: 8] = 8'((r << 4) | c);
         step(1'b1, r, row, 1'b0, 1'b0, 0);
      end
      step(1'b0, 0, '0, 1'b0, 1'b0, 0);

      step(1'b0, 0, '0, 1'b1, 1'b1, 1, 1'b1, 32'h31211101);
      step(1'b0, 0, '0, 1'b0, 1'b0, 0);
      step(1'b0, 0, '0, 1'b1, 1'b0, 2, 1'b1, 32'h23222120);
      step(1'b0, 0, '0, 1'b0, 1'b0, 0);
      step(1'b0, 0, '0, 1'b0, 1'b0, 0);

      // Back-to-back column reads.
      step(1'b0, 0, '0, 1'b1, 1'b1, 0, 1'b1, 32'h30201000);
      step(1'b0, 0, '0, 1'b1, 1'b1, 1, 1'b1, 32'h31211101);
      step(1'b0, 0, '0, 1'b1, 1'b1, 2, 1'b1, 32'h32221202);
      step(1'b0, 0, '0, 1'b1, 1'b1, 3, 1'b1, 32'h33231303);
      step(1'b0, 0, '0, 1'b0, 1'b0, 0);

      // Collision: same-edge read sees old row, next-edge read sees new row.
      step(1'b1, 1, 32'hAAAAAAAA, 1'b1, 1'b0, 1, 1'b1, 32'h13121110);
      step(1'b0, 0, '0, 1'b1, 1'b0, 1, 1'b1, 32'hAAAAAAAA);
      step(1'b0, 0, '0, 1'b1, 1'b1, 2);
      step(1'b0, 0, '0, 1'b0, 1'b0, 0);

      // Random concurrent traffic against the model.
      for (int k = 0; k < 40; k++) begin
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      repeat (LAT + 2) step(1'b0, 0, '0, 1'b0, 1'b0, 0);
      check("sb_empty_pre_reset", 64'(sb.size()), 64'd0);

      // Reset with a read in flight: it must be dropped.
      step(1'b0, 0, '0, 1'b1, 1'b1, 3);
      @(posedge clk);
      #2;
      ren   = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rvalid_at_reset", {63'd0, rvalid}, 64'd0);
      check("rdata_at_reset", {32'd0, rdata}, 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);

      // Release with a read presented for the very first edge after release.
      @(negedge clk);
      rst_n = 1'b1;
      ren   = 1'b1;
      rmode = 1'b0;
      raddr = 2'd1;
      e.data  = model_read(1'b0, 1);
      e.mode  = 1'b0;
      e.issue = cyc + 1;
      sb.push_back(e);
      step(1'b0, 0, '0, 1'b0, 1'b0, 0);
      repeat (LAT + 3) step(1'b0, 0, '0, 1'b0, 1'b0, 0);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
